// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Latency: none, these are combinational helpers.
// Backpressure: not applicable.
package rr_grant_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Widest requester vector the one-hot helper can produce; callers truncate.
    localparam int unsigned OH_MAX = 1024;

    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned width);
        return (idx + 1 >= width) ? 0 : idx + 1;
    endfunction

    function automatic logic [OH_MAX-1:0] idx2oh(input int unsigned idx);
        logic [OH_MAX-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/programmable_priority_encoder.sv
// Priority encoder with a programmable floor: lowest set bit at/above enc_pri, and lowest overall.
// Latency: purely combinational, SPLIT-ary reduction tree.
// Backpressure: not applicable.
module programmable_priority_encoder #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 2,
    localparam int LOG  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] dec_vld_h,
    input  logic [WIDTH-1:0] dec_vld_l,
    input  logic [LOG-1:0]   enc_pri,
    output logic             enc_vld_h,
    output logic [LOG-1:0]   enc_idx_h,
    output logic             enc_vld_l,
    output logic [LOG-1:0]   enc_idx_l,
    output logic             enc_vld
);

    logic [WIDTH-1:0] mask_h;

    // Each tree level folds SPLIT neighbours into one node, lowest child winning.
    function automatic logic [LOG:0] tree_find(input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0]          v;
        logic [WIDTH-1:0]          nv;
        logic [WIDTH-1:0][LOG-1:0] ix;
        logic [WIDTH-1:0][LOG-1:0] nix;
        v = m;
        for (int i = 0; i < WIDTH; i++) begin
            ix[i] = LOG'(i);
        end
        for (int cnt = WIDTH / SPLIT; cnt >= 1; cnt = cnt / SPLIT) begin
            nv  = '0;
            nix = '0;
            for (int g = 0; g < cnt; g++) begin
                for (int j = SPLIT - 1; j >= 0; j--) begin
                    if (v[g*SPLIT+j]) begin
                        nv[g]  = 1'b1;
                        nix[g] = ix[g*SPLIT+j];
                    end
                end
            end
            v  = nv;
            ix = nix;
        end
        return {v[0], ix[0]};
    endfunction

    always_comb begin
        mask_h = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_h[i] = dec_vld_h[i] && (i >= int'(enc_pri));
        end
    end

    assign {enc_vld_h, enc_idx_h} = tree_find(mask_h);
    assign {enc_vld_l, enc_idx_l} = tree_find(dec_vld_l);
    assign enc_vld                = enc_vld_h | enc_vld_l;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter; optional grant locking under RR_GRANT_ARBITER_LOCK_EN.
// Latency: req seen at an edge -> grt_vld the next cycle; one grant per cycle sustained.
// Backpressure: grant held stable while grt_rdy is low; ptr moves only on transfer.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SPLIT     = 2,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
`ifdef RR_GRANT_ARBITER_LOCK_EN
    input  logic                 grt_lock,
`endif
    output logic                 grt_vld,
    input  logic                 grt_rdy,
    output logic [WIDTH_LOG-1:0] grt_idx,
    output logic [WIDTH-1:0]     grt_oh,
    output logic [WIDTH_LOG-1:0] ptr
);

    state_t               state;
    state_t               state_nxt;
    logic                 lock;
    logic                 xfer;
    logic                 load;
    logic [WIDTH_LOG-1:0] adv_ptr;
    logic [WIDTH_LOG-1:0] enc_pri;
    logic [WIDTH_LOG-1:0] win_idx;
    logic [WIDTH_LOG-1:0] enc_idx_h;
    logic [WIDTH_LOG-1:0] enc_idx_l;
    logic                 enc_vld_h;
    logic                 enc_vld_l;
    logic                 enc_vld;

`ifdef RR_GRANT_ARBITER_LOCK_EN
    assign lock = grt_lock;
`else
    assign lock = 1'b0;
`endif

    assign xfer    = grt_vld & grt_rdy;
    assign adv_ptr = WIDTH_LOG'(next_ptr(int'(grt_idx), WIDTH));

    // While granting, arbitrate against the pointer the transfer would leave behind,
    // so back-to-back grants see the updated rotation without waiting a cycle.
    assign enc_pri = (state == GRANT) ? (lock ? grt_idx : adv_ptr) : ptr;

    programmable_priority_encoder #(
        .WIDTH (WIDTH),
        .SPLIT (SPLIT)
    ) u_enc (
        .dec_vld_h (req),
        .dec_vld_l (req),
        .enc_pri   (enc_pri),
        .enc_vld_h (enc_vld_h),
        .enc_idx_h (enc_idx_h),
        .enc_vld_l (enc_vld_l),
        .enc_idx_l (enc_idx_l),
        .enc_vld   (enc_vld)
    );

    assign win_idx = enc_vld_h ? enc_idx_h : enc_idx_l;
    assign load    = ((state == IDLE) || xfer) && enc_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enc_vld) state_nxt = GRANT;
            GRANT:   if (xfer)    state_nxt = enc_vld ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grt_idx <= '0;
            ptr     <= '0;
        end else begin
            if (load) begin
                grt_idx <= win_idx;
            end
            if (xfer && !lock) begin
                ptr <= adv_ptr;
            end
        end
    end

    always_comb begin
        grt_vld = (state == GRANT);
        grt_oh  = grt_vld ? WIDTH'(idx2oh(int'(grt_idx))) : '0;
    end

endmodule
